// File: rtl/fetch_pkg.sv
// fetch_pkg: shared redirect types for the fetch redirect controller
package fetch_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    REDIR_NONE    = 2'd0,
    REDIR_EJ      = 2'd1,
    REDIR_MISPRED = 2'd2,
    REDIR_EXCEPT  = 2'd3
  } redir_cause_t;
  typedef struct packed {
    redir_cause_t    cause;
    logic [XLEN-1:0] pc;
  } redir_req_t;
endpackage

// File: rtl/fetch_inflight_cnt.sv
// fetch_inflight_cnt: outstanding I-mem request counter and stale-response tracker
module fetch_inflight_cnt #(
  parameter int MAX_INFLIGHT = 4,
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_fire_i,
  input  logic rsp_valid_i,
  input  logic redir_accept_i,
  output logic req_allow_o,
  output logic rsp_drop_o
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INFLIGHT);
  logic [CNT_W-1:0] inflight_q, inflight_d, stale_q, stale_d;
  // Saturating inflight update; a redirect makes every request still in flight after this cycle stale
  always_comb begin
    inflight_d = (req_fire_i && !rsp_valid_i && inflight_q != MAX_C) ? inflight_q + 1'b1 :
                 (rsp_valid_i && !req_fire_i && inflight_q != '0)   ? inflight_q - 1'b1 : inflight_q;
    stale_d    = redir_accept_i              ? inflight_d :
                 (rsp_valid_i && stale_q != '0) ? stale_q - 1'b1 : stale_q;
  end
  // Counter state, cleared immediately by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      stale_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
    end
  end
  assign req_allow_o = inflight_q < MAX_C;
  assign rsp_drop_o  = rsp_valid_i && stale_q != '0;
  a_fire_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(req_fire_i && !req_allow_o && !rsp_valid_i));
  a_rsp_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_valid_i && inflight_q == '0));
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: redirect arbitration/hold for pc_gen with stale-response marking (optional FETCH_REDIR_STATS_EN counters)
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            except_valid_i,
  input  logic [XLEN-1:0] except_pc_i,
  input  logic            mispred_valid_i,
  input  logic [XLEN-1:0] mispred_pc_i,
  input  logic            ej_valid_i,
  input  logic [XLEN-1:0] ej_pc_i,
  input  logic            redir_ack_i,
  input  logic            req_fire_i,
  input  logic            rsp_valid_i,
`ifdef FETCH_REDIR_STATS_EN
  output logic [31:0]     stat_except_o,
  output logic [31:0]     stat_mispred_o,
  output logic [31:0]     stat_ej_o,
  output logic [31:0]     stat_drop_o,
`endif
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_pc_o,
  output redir_cause_t    redir_cause_o,
  output logic            flush_o,
  output logic            rsp_drop_o,
  output logic            req_allow_o
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t     state_q, state_d;
  redir_req_t slot_q, slot_d, live, cand;
  logic       accept;
  // Highest-priority live request; held slot only wins when strictly higher (newer wins ties)
  always_comb begin
    live = except_valid_i  ? redir_req_t'{cause: REDIR_EXCEPT,  pc: except_pc_i}  :
           mispred_valid_i ? redir_req_t'{cause: REDIR_MISPRED, pc: mispred_pc_i} :
           ej_valid_i      ? redir_req_t'{cause: REDIR_EJ,      pc: ej_pc_i}      : '0;
    cand = (state_q == PENDING && slot_q.cause > live.cause) ? slot_q : live;
  end
  // Next state: hold the winner until pc_gen acknowledges it
  always_comb begin
    state_d = (cand.cause != REDIR_NONE && !redir_ack_i) ? PENDING : IDLE;
    slot_d  = (state_d == PENDING) ? cand : '0;
  end
  // State register and pending slot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end
  // Outputs straight from the candidate, giving a zero-cycle path when idle
  always_comb begin
    redir_valid_o = cand.cause != REDIR_NONE;
    redir_pc_o    = cand.pc;
    redir_cause_o = cand.cause;
    accept        = redir_valid_o && redir_ack_i;
    flush_o       = accept && cand.cause >= REDIR_MISPRED;
  end
  fetch_inflight_cnt #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_cnt (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_fire_i     (req_fire_i),
    .rsp_valid_i    (rsp_valid_i),
    .redir_accept_i (accept),
    .req_allow_o    (req_allow_o),
    .rsp_drop_o     (rsp_drop_o)
  );
`ifdef FETCH_REDIR_STATS_EN
  // Per-cause accepted-redirect and dropped-response counters, wrapping at 2^32
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_except_o  <= '0;
      stat_mispred_o <= '0;
      stat_ej_o      <= '0;
      stat_drop_o    <= '0;
    end else begin
      stat_except_o  <= stat_except_o  + 32'(accept && cand.cause == REDIR_EXCEPT);
      stat_mispred_o <= stat_mispred_o + 32'(accept && cand.cause == REDIR_MISPRED);
      stat_ej_o      <= stat_ej_o      + 32'(accept && cand.cause == REDIR_EJ);
      stat_drop_o    <= stat_drop_o    + 32'(rsp_drop_o);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed scoreboard bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
  import fetch_pkg::*;
  logic            clk_i = 1'b0, rst_i = 1'b1;
  logic            except_valid_i = 1'b0, mispred_valid_i = 1'b0, ej_valid_i = 1'b0;
  logic [XLEN-1:0] except_pc_i = '0, mispred_pc_i = '0, ej_pc_i = '0;
  logic            redir_ack_i = 1'b0, req_fire_i = 1'b0, rsp_valid_i = 1'b0;
  logic            redir_valid_o, flush_o, rsp_drop_o, req_allow_o;
  logic [XLEN-1:0] redir_pc_o;
  redir_cause_t    redir_cause_o;
  typedef struct {
    string       nm;
    logic        v;
    logic [31:0] pc;
    logic [1:0]  c;
    logic        f;
    logic        d;
    logic        a;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  fetch_redirect_ctrl #(.MAX_INFLIGHT(4)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .except_valid_i  (except_valid_i),
    .except_pc_i     (except_pc_i),
    .mispred_valid_i (mispred_valid_i),
    .mispred_pc_i    (mispred_pc_i),
    .ej_valid_i      (ej_valid_i),
    .ej_pc_i         (ej_pc_i),
    .redir_ack_i     (redir_ack_i),
    .req_fire_i      (req_fire_i),
    .rsp_valid_i     (rsp_valid_i),
    .redir_valid_o   (redir_valid_o),
    .redir_pc_o      (redir_pc_o),
    .redir_cause_o   (redir_cause_o),
    .flush_o         (flush_o),
    .rsp_drop_o      (rsp_drop_o),
    .req_allow_o     (req_allow_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ({redir_valid_o, redir_pc_o, 2'(redir_cause_o), flush_o, rsp_drop_o, req_allow_o} !==
          {e.v, e.pc, e.c, e.f, e.d, e.a}) begin
        n_bad++;
        $display("FAIL %s: got v=%b pc=%h cause=%0d flush=%b drop=%b allow=%b, want v=%b pc=%h cause=%0d flush=%b drop=%b allow=%b",
                 e.nm, redir_valid_o, redir_pc_o, redir_cause_o, flush_o, rsp_drop_o, req_allow_o,
                 e.v, e.pc, e.c, e.f, e.d, e.a);
      end
    end
  end
  task automatic step(input string nm, input logic ex, input logic [31:0] epc,
                      input logic mp, input logic [31:0] mpc, input logic ej, input logic [31:0] jpc,
                      input logic ack, input logic fire, input logic rsp,
                      input logic v, input logic [31:0] pc, input logic [1:0] c,
                      input logic f, input logic d, input logic a);
    except_valid_i = ex; except_pc_i = epc;
    mispred_valid_i = mp; mispred_pc_i = mpc;
    ej_valid_i = ej; ej_pc_i = jpc;
    redir_ack_i = ack; req_fire_i = fire; rsp_valid_i = rsp;
    q.push_back('{nm, v, pc, c, f, d, a});
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    @(posedge clk_i);
    #1;
    step("rst_state",   0,0, 0,0, 0,0,            0,0,0, 0,0,0,0,0,1);
    rst_i = 1'b0;
    step("idle0",       0,0, 0,0, 0,0,            0,0,0, 0,0,0,0,0,1);
    step("ej_bypass",   0,0, 0,0, 1,32'h1000,     1,0,0, 1,32'h1000,1,0,0,1);
    step("ej_idle",     0,0, 0,0, 0,0,            0,0,0, 0,0,0,0,0,1);
    step("mp_hold0",    0,0, 1,32'h2000, 0,0,     0,0,0, 1,32'h2000,2,0,0,1);
    step("mp_hold1",    0,0, 0,0, 0,0,            0,0,0, 1,32'h2000,2,0,0,1);
    step("mp_hold2",    0,0, 0,0, 0,0,            0,0,0, 1,32'h2000,2,0,0,1);
    step("mp_ack",      0,0, 0,0, 0,0,            1,0,0, 1,32'h2000,2,1,0,1);
    step("mp_idle",     0,0, 0,0, 0,0,            0,0,0, 0,0,0,0,0,1);
    step("pre_mp",      0,0, 1,32'h2000, 0,0,     0,0,0, 1,32'h2000,2,0,0,1);
    step("exc_over",    1,32'h8000, 0,0, 0,0,     0,0,0, 1,32'h8000,3,0,0,1);
    step("ej_ignored",  0,0, 0,0, 1,32'h3000,     0,0,0, 1,32'h8000,3,0,0,1);
    step("exc_ack",     0,0, 0,0, 0,0,            1,0,0, 1,32'h8000,3,1,0,1);
    step("exc_idle",    0,0, 0,0, 0,0,            0,0,0, 0,0,0,0,0,1);
    step("fire0",       0,0, 0,0, 0,0,            0,1,0, 0,0,0,0,0,1);
    step("fire1",       0,0, 0,0, 0,0,            0,1,0, 0,0,0,0,0,1);
    step("fire2",       0,0, 0,0, 0,0,            0,1,0, 0,0,0,0,0,1);
    step("mp_ack_fire", 0,0, 1,32'h4000, 0,0,     1,1,0, 1,32'h4000,2,1,0,1);
    step("drop0",       0,0, 0,0, 0,0,            0,0,1, 0,0,0,0,1,0);
    step("drop1",       0,0, 0,0, 0,0,            0,0,1, 0,0,0,0,1,1);
    step("drop2",       0,0, 0,0, 0,0,            0,0,1, 0,0,0,0,1,1);
    step("drop3",       0,0, 0,0, 0,0,            0,0,1, 0,0,0,0,1,1);
    step("fire_after",  0,0, 0,0, 0,0,            0,1,0, 0,0,0,0,0,1);
    step("rsp_live",    0,0, 0,0, 0,0,            0,0,1, 0,0,0,0,0,1);
    step("fill0",       0,0, 0,0, 0,0,            0,1,0, 0,0,0,0,0,1);
    step("fill1",       0,0, 0,0, 0,0,            0,1,0, 0,0,0,0,0,1);
    step("fill2",       0,0, 0,0, 0,0,            0,1,0, 0,0,0,0,0,1);
    step("fill3",       0,0, 0,0, 0,0,            0,1,0, 0,0,0,0,0,1);
    step("full",        0,0, 0,0, 0,0,            0,0,0, 0,0,0,0,0,0);
    step("full_fr",     0,0, 0,0, 0,0,            0,1,1, 0,0,0,0,0,0);
    step("still_full",  0,0, 0,0, 0,0,            0,0,0, 0,0,0,0,0,0);
    step("drain0",      0,0, 0,0, 0,0,            0,0,1, 0,0,0,0,0,0);
    step("drain1",      0,0, 0,0, 0,0,            0,0,1, 0,0,0,0,0,1);
    step("drain2",      0,0, 0,0, 0,0,            0,0,1, 0,0,0,0,0,1);
    step("drain3",      0,0, 0,0, 0,0,            0,0,1, 0,0,0,0,0,1);
    step("prio_both",   1,32'h9000, 1,32'h7000, 0,0, 1,0,0, 1,32'h9000,3,1,0,1);
    step("eq0",         0,0, 1,32'h7000, 0,0,     0,0,0, 1,32'h7000,2,0,0,1);
    step("eq_newer",    0,0, 1,32'h7100, 0,0,     0,0,0, 1,32'h7100,2,0,0,1);
    step("eq_ack",      0,0, 0,0, 0,0,            1,0,0, 1,32'h7100,2,1,0,1);
    step("pre_f0",      0,0, 0,0, 0,0,            0,1,0, 0,0,0,0,0,1);
    step("pre_f1",      0,0, 0,0, 0,0,            0,1,0, 0,0,0,0,0,1);
    step("mp_stale2",   0,0, 1,32'h5000, 0,0,     1,0,0, 1,32'h5000,2,1,0,1);
    step("ej_pend",     0,0, 0,0, 1,32'h6000,     0,0,0, 1,32'h6000,1,0,0,1);
    rst_i = 1'b1;
    step("rst_mid",     0,0, 0,0, 0,0,            0,0,1, 0,0,0,0,0,1);
    rst_i = 1'b0;
    step("post_rst",    0,0, 0,0, 0,0,            0,0,0, 0,0,0,0,0,1);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk_i);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
